// File: rtl/csc_pkg.sv
// Shared constants for the colour-space converter coefficient controller:
// widths, register map, preset matrices and FSM encoding.
package csc_pkg;

    localparam int CW       = 11;
    localparam int OW       = 8;
    localparam int NUM_COEF = 9;
    localparam int NUM_OFF  = 3;

    localparam logic [3:0] ADDR_M11    = 4'd0;
    localparam logic [3:0] ADDR_M33    = 4'd8;
    localparam logic [3:0] ADDR_OFF_Y  = 4'd9;
    localparam logic [3:0] ADDR_OFF_CB = 4'd10;
    localparam logic [3:0] ADDR_OFF_CR = 4'd11;

    // Element 0 is M11 (listed last in each concatenation), element 8 is M33.
    localparam logic [NUM_COEF-1:0][CW-1:0] BT601_COEF = {
        11'h7AD, 11'h653, 11'h200,
        11'h200, 11'h6AD, 11'h753,
        11'h075, 11'h259, 11'h132
    };
    localparam logic [NUM_COEF-1:0][CW-1:0] BT709_COEF = {
        11'h7D1, 11'h62F, 11'h200,
        11'h200, 11'h675, 11'h78B,
        11'h04A, 11'h2DC, 11'h0DA
    };
    localparam logic [NUM_OFF-1:0][OW-1:0] BT601_OFF = {8'd128, 8'd128, 8'd0};
    localparam logic [NUM_OFF-1:0][OW-1:0] BT709_OFF = {8'd128, 8'd128, 8'd0};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } state_t;

endpackage

// File: rtl/csc_blank_guard.sv
// Counts consecutive frame-valid-low cycles while armed; met flags the cycle
// on which the count reaches GUARD.
module csc_blank_guard #(
    parameter int GUARD = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic run,
    input  logic frame_valid,
    output logic met
);

    localparam int GW = $clog2(GUARD + 1);

    logic [GW-1:0] count_reg;
    logic [GW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (!run || frame_valid) begin
            count_next = '0;
        end else if (count_reg != GW'(GUARD)) begin
            count_next = count_reg + 1'b1;
        end
    end

    // Combinational so the FSM can leave PENDING on the same edge the count lands.
    assign met = run && !frame_valid && (count_next == GW'(GUARD));

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/csc_coef_ctrl.sv
// Shadow/active coefficient banks for rgb2ycbcr; shadow is copied to active
// only after a committed request sees enough vertical blanking.
module csc_coef_ctrl
    import csc_pkg::*;
#(
    parameter int GUARD = 2
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iWrEn,
    input  logic [3:0]          iWrAddr,
    input  logic [CW-1:0]       iWrData,
    input  logic                iPresetLoad,
    input  logic                iPresetSel,
    input  logic                iCommit,
    input  logic                iFrameValid,
    output logic                oWrReady,
    output logic                oPending,
    output logic                oApplied,
    output logic [9*CW-1:0]     oCoef,
    output logic [3*OW-1:0]     oOff
);

    state_t state_reg;
    state_t state_next;

    logic wr_ready_reg, wr_ready_next;
    logic pending_reg,  pending_next;
    logic applied_reg,  applied_next;

    logic accept;
    logic preset_load;
    logic wr_en;
    logic guard_run;
    logic guard_met;

    logic [CW-1:0] shadow_coef_reg [NUM_COEF];
    logic [CW-1:0] active_coef_reg [NUM_COEF];
    logic [OW-1:0] shadow_off_reg  [NUM_OFF];
    logic [OW-1:0] active_off_reg  [NUM_OFF];

    // A preset overrides a same-cycle register write.
    assign accept      = (state_reg == ST_IDLE);
    assign preset_load = accept && iPresetLoad;
    assign wr_en       = accept && iWrEn && !iPresetLoad;
    assign guard_run   = (state_reg == ST_PENDING);

    csc_blank_guard #(
        .GUARD(GUARD)
    ) u_guard (
        .clk        (iClk),
        .srst       (iRst),
        .run        (guard_run),
        .frame_valid(iFrameValid),
        .met        (guard_met)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_reg    <= ST_IDLE;
            wr_ready_reg <= 1'b1;
            pending_reg  <= 1'b0;
            applied_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_ready_reg <= wr_ready_next;
            pending_reg  <= pending_next;
            applied_reg  <= applied_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (iCommit) state_next = ST_PENDING;
            ST_PENDING: if (guard_met) state_next = ST_APPLY;
            ST_APPLY:   state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Flags are decoded from the next state so they line up with state_reg.
    always_comb begin
        wr_ready_next = (state_next == ST_IDLE);
        pending_next  = (state_next == ST_PENDING);
        applied_next  = (state_next == ST_APPLY);
    end

    assign oWrReady = wr_ready_reg;
    assign oPending = pending_reg;
    assign oApplied = applied_reg;

    for (genvar gi = 0; gi < NUM_COEF; gi++) begin : g_coef
        logic wr_hit;
        assign wr_hit = wr_en && (iWrAddr == 4'(ADDR_M11 + gi));

        always_ff @(posedge iClk) begin
            if (iRst) begin
                shadow_coef_reg[gi] <= BT601_COEF[gi];
                active_coef_reg[gi] <= BT601_COEF[gi];
            end else begin
                if (preset_load) begin
                    shadow_coef_reg[gi] <= iPresetSel ? BT709_COEF[gi] : BT601_COEF[gi];
                end else if (wr_hit) begin
                    shadow_coef_reg[gi] <= iWrData;
                end
                if (state_reg == ST_APPLY) begin
                    active_coef_reg[gi] <= shadow_coef_reg[gi];
                end
            end
        end

        assign oCoef[gi*CW +: CW] = active_coef_reg[gi];
    end

    for (genvar gi = 0; gi < NUM_OFF; gi++) begin : g_off
        logic wr_hit;
        assign wr_hit = wr_en && (iWrAddr == 4'(ADDR_OFF_Y + gi));

        always_ff @(posedge iClk) begin
            if (iRst) begin
                shadow_off_reg[gi] <= BT601_OFF[gi];
                active_off_reg[gi] <= BT601_OFF[gi];
            end else begin
                if (preset_load) begin
                    shadow_off_reg[gi] <= iPresetSel ? BT709_OFF[gi] : BT601_OFF[gi];
                end else if (wr_hit) begin
                    shadow_off_reg[gi] <= iWrData[OW-1:0];
                end
                if (state_reg == ST_APPLY) begin
                    active_off_reg[gi] <= shadow_off_reg[gi];
                end
            end
        end

        assign oOff[gi*OW +: OW] = active_off_reg[gi];
    end

endmodule
